// File: rtl/usb2_ep_router.sv
// usb2_ep_router: routes packet-layer commit/arm requests to one of NUM_EP
// endpoint buffers. The endpoint number is latched on txn_start and held until
// the transaction ends or an ack timeout aborts it. The block also keeps the
// per-endpoint data toggle and halt state.
// Optional build macro USB2_EP_ROUTER_STATS_EN adds saturating txn/timeout/stall
// counters.

// Per-endpoint toggle and halt state.
module usb2_ep_router_ep #(
  parameter bit         IS_EP0 = 1'b0,
  parameter logic [1:0] MODE   = 2'd0
) (
  input  logic       phy_clk,
  input  logic       reset_n,
  input  logic       sel_hit,
  input  logic       setconfig,
  input  logic       halt_clr,
  input  logic       halt_set,
  input  logic       setup_rx,
  input  logic       tog_act,
  output logic [1:0] toggle,
  output logic       halted
);
  localparam logic [1:0] MODE_ISOCH = 2'd1;

  // Priority on this endpoint: setconfig > halt_clr > setup_rx > toggle advance.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle <= 2'b00;
      halted <= 1'b0;
    end else if (setconfig && !IS_EP0) begin
      toggle <= 2'b00;
      halted <= 1'b0;
    end else if (halt_clr && sel_hit) begin
      toggle <= 2'b00;
      halted <= 1'b0;
    end else begin
      if (setup_rx && IS_EP0)
        toggle <= 2'b01;
      else if (tog_act && sel_hit)
        toggle <= (MODE == MODE_ISOCH) ? 2'b00 : {1'b0, ~toggle[0]};
      // A STALL on EP0 only lasts until the next SETUP.
      if (setup_rx && IS_EP0)
        halted <= 1'b0;
      else if (halt_set && sel_hit)
        halted <= 1'b1;
    end
  end
endmodule

module usb2_ep_router #(
  parameter int                  NUM_EP      = 5,
  parameter logic [2*NUM_EP-1:0] EP_MODES    = 10'b10_01_10_10_00,
  parameter int                  ACK_TIMEOUT = 255
) (
  input  logic                  phy_clk,
  input  logic                  reset_n,
  input  logic [3:0]            sel_endp,
  input  logic                  txn_start,
  input  logic                  txn_end,
  input  logic                  buf_in_commit,
  input  logic                  buf_out_arm,
  input  logic                  data_toggle_act,
  input  logic                  setup_rx,
  input  logic                  setconfig,
  input  logic                  halt_set,
  input  logic                  halt_clr,
  input  logic [NUM_EP-1:0]     ep_hasdata,
  input  logic [8*NUM_EP-1:0]   ep_buf_out_q,
  input  logic [NUM_EP-1:0]     ep_commit_ack,
  input  logic [NUM_EP-1:0]     ep_arm_ack,
  output logic [NUM_EP-1:0]     ep_commit,
  output logic [NUM_EP-1:0]     ep_arm,
  output logic                  buf_in_commit_ack,
  output logic                  buf_out_arm_ack,
  output logic [7:0]            buf_out_q,
  output logic                  buf_out_hasdata,
  output logic [1:0]            endp_mode,
  output logic [1:0]            data_toggle,
  output logic                  endp_halted,
  output logic                  endp_invalid,
  output logic                  ack_timeout,
`ifdef USB2_EP_ROUTER_STATS_EN
  output logic [15:0]           txn_count,
  output logic [7:0]            timeout_count,
  output logic [7:0]            stall_count,
`endif
  output logic                  busy
);
  localparam int EW = $clog2(NUM_EP);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_C, WAIT_A} state_t;

  state_t                   state, state_d;
  logic [3:0]               sel_q, sel_d;
  logic [CW-1:0]            cnt, cnt_d;
  logic                     c_ack_d, a_ack_d, to_d;
  logic                     blocked;
  logic                     ep_inval;
  logic [NUM_EP-1:0]        sel_hit_v;
  logic [NUM_EP-1:0]        halt_v;
  logic [NUM_EP-1:0][1:0]   tog_v;
  logic [NUM_EP-1:0][1:0]   mode_v;
  logic [NUM_EP-1:0][7:0]   bq_v;
  logic                     cur_halt;
  logic                     req;

  assign bq_v      = ep_buf_out_q;
  assign ep_inval  = (32'(sel_q) >= NUM_EP);
  // One-hot of the latched endpoint; all-zero when the number is out of range.
  assign sel_hit_v = (NUM_EP'(1) << sel_q[EW-1:0]) & {NUM_EP{~ep_inval}};
  assign cur_halt  = |(halt_v & sel_hit_v);
  assign req       = buf_in_commit | buf_out_arm;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_EP; gi++) begin : g_ep
      localparam logic [1:0] M = (gi == 0) ? 2'd0 : EP_MODES[2*gi +: 2];
      assign mode_v[gi] = M;
      usb2_ep_router_ep #(.IS_EP0(gi == 0), .MODE(M)) u_ep (
        .phy_clk   (phy_clk),
        .reset_n   (reset_n),
        .sel_hit   (sel_hit_v[gi]),
        .setconfig (setconfig),
        .halt_clr  (halt_clr),
        .halt_set  (halt_set),
        .setup_rx  (setup_rx),
        .tog_act   (data_toggle_act),
        .toggle    (tog_v[gi]),
        .halted    (halt_v[gi])
      );
    end
  endgenerate

  // Muxed view of the latched endpoint; zero for an out-of-range number.
  always_comb begin
    buf_out_q       = 8'h00;
    buf_out_hasdata = 1'b0;
    endp_mode       = 2'd0;
    data_toggle     = 2'd0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (sel_hit_v[i]) begin
        buf_out_q       = bq_v[i];
        buf_out_hasdata = ep_hasdata[i];
        endp_mode       = mode_v[i];
        data_toggle     = tog_v[i];
      end
    end
  end

  assign endp_halted  = cur_halt;
  assign endp_invalid = ep_inval;

  // Requests come straight from the state register so an async reset drops them at once.
  assign ep_commit = (state == WAIT_C) ? sel_hit_v : '0;
  assign ep_arm    = (state == WAIT_A) ? sel_hit_v : '0;
  assign busy      = (state != IDLE);

  // Transaction FSM state, latched select, timeout counter and pulse outputs.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      sel_q             <= 4'd0;
      cnt               <= '0;
      buf_in_commit_ack <= 1'b0;
      buf_out_arm_ack   <= 1'b0;
      ack_timeout       <= 1'b0;
    end else begin
      state             <= state_d;
      sel_q             <= sel_d;
      cnt               <= cnt_d;
      buf_in_commit_ack <= c_ack_d;
      buf_out_arm_ack   <= a_ack_d;
      ack_timeout       <= to_d;
    end
  end

  // Next state: commit beats arm; an ack beats a timeout in the same cycle.
  always_comb begin
    state_d = state;
    sel_d   = sel_q;
    cnt_d   = cnt;
    c_ack_d = 1'b0;
    a_ack_d = 1'b0;
    to_d    = 1'b0;
    blocked = 1'b0;
    case (state)
      IDLE: begin
        if (txn_start) begin
          sel_d   = sel_endp;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        blocked = req & (cur_halt | ep_inval);
        if (req && !(cur_halt || ep_inval)) begin
          cnt_d   = '0;
          state_d = buf_in_commit ? WAIT_C : WAIT_A;
        end else if (txn_end) begin
          state_d = IDLE;
        end
      end
      WAIT_C, WAIT_A: begin
        if ((state == WAIT_C) ? |(ep_commit_ack & sel_hit_v) : |(ep_arm_ack & sel_hit_v)) begin
          c_ack_d = (state == WAIT_C);
          a_ack_d = (state == WAIT_A);
          state_d = ACTIVE;
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef USB2_EP_ROUTER_STATS_EN
  // Saturating activity counters, cleared along with the configuration.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      txn_count     <= '0;
      timeout_count <= '0;
      stall_count   <= '0;
    end else if (setconfig) begin
      txn_count     <= '0;
      timeout_count <= '0;
      stall_count   <= '0;
    end else begin
      if ((buf_in_commit_ack || buf_out_arm_ack) && (txn_count != 16'hFFFF))
        txn_count <= txn_count + 16'd1;
      if (ack_timeout && (timeout_count != 8'hFF))
        timeout_count <= timeout_count + 8'd1;
      if (blocked && (stall_count != 8'hFF))
        stall_count <= stall_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb2_ep_router.sv
// Bench for usb2_ep_router: directed scenarios with a queue of expected
// ack/timeout events, compared as the pulses appear.
module tb_usb2_ep_router;
  localparam int NEP = 5;

  logic             phy_clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       sel_endp = '0;
  logic             txn_start = 0, txn_end = 0, buf_in_commit = 0, buf_out_arm = 0;
  logic             data_toggle_act = 0, setup_rx = 0, setconfig = 0, halt_set = 0, halt_clr = 0;
  logic [NEP-1:0]   ep_hasdata = '0;
  logic [8*NEP-1:0] ep_buf_out_q = '0;
  logic [NEP-1:0]   ep_commit_ack = '0, ep_arm_ack = '0;
  logic [NEP-1:0]   ep_commit, ep_arm;
  logic             buf_in_commit_ack, buf_out_arm_ack, buf_out_hasdata;
  logic [7:0]       buf_out_q;
  logic [1:0]       endp_mode, data_toggle;
  logic             endp_halted, endp_invalid, ack_timeout, busy;

  int checks = 0;
  int errors = 0;
  // Expected event codes: {ack_timeout, buf_out_arm_ack, buf_in_commit_ack}.
  logic [2:0] exp_q[$];

  usb2_ep_router #(.NUM_EP(NEP), .EP_MODES(10'b10_01_10_10_00), .ACK_TIMEOUT(8)) dut (
    .phy_clk(phy_clk), .reset_n(reset_n), .sel_endp(sel_endp),
    .txn_start(txn_start), .txn_end(txn_end),
    .buf_in_commit(buf_in_commit), .buf_out_arm(buf_out_arm),
    .data_toggle_act(data_toggle_act), .setup_rx(setup_rx), .setconfig(setconfig),
    .halt_set(halt_set), .halt_clr(halt_clr),
    .ep_hasdata(ep_hasdata), .ep_buf_out_q(ep_buf_out_q),
    .ep_commit_ack(ep_commit_ack), .ep_arm_ack(ep_arm_ack),
    .ep_commit(ep_commit), .ep_arm(ep_arm),
    .buf_in_commit_ack(buf_in_commit_ack), .buf_out_arm_ack(buf_out_arm_ack),
    .buf_out_q(buf_out_q), .buf_out_hasdata(buf_out_hasdata),
    .endp_mode(endp_mode), .data_toggle(data_toggle),
    .endp_halted(endp_halted), .endp_invalid(endp_invalid),
    .ack_timeout(ack_timeout), .busy(busy)
  );

  always #5 phy_clk = ~phy_clk;

  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask

  // Bounded wait for any ack/timeout pulse; returns 0 if none appeared.
  task automatic wait_evt(input int budget, output logic [2:0] code);
    code = 3'b000;
    for (int i = 0; i <= budget; i++) begin
      code = {ack_timeout, buf_out_arm_ack, buf_in_commit_ack};
      if (code != 3'b000) return;
      tick();
    end
  endtask

  // Pops the next expected event; an impossible code if nothing was queued.
  function automatic logic [2:0] pop_exp();
    if (exp_q.size() == 0) return 3'b111;
    return exp_q.pop_front();
  endfunction

  task automatic start_txn(input logic [3:0] ep);
    sel_endp = ep; txn_start = 1; tick(); txn_start = 0;
  endtask

  task automatic end_txn();
    txn_end = 1; tick(); txn_end = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    tick(); tick();
    checks++;
    if ({ep_commit, ep_arm, buf_in_commit_ack, buf_out_arm_ack, ack_timeout, busy} !== '0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0", {ep_commit, ep_arm, buf_in_commit_ack, buf_out_arm_ack, ack_timeout, busy});
    end
    reset_n = 1;
    tick();
    checks++;
    if ({buf_out_q, buf_out_hasdata, endp_mode, data_toggle, endp_halted, endp_invalid, busy} !== '0) begin
      errors++; $display("FAIL reset_mux got=%h exp=0", {buf_out_q, buf_out_hasdata, endp_mode, data_toggle, endp_halted, endp_invalid, busy});
    end
  endtask

  task automatic test_commit();
    logic [2:0] got, exp;
    start_txn(4'd2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL commit_busy got=%b exp=1", busy); end
    exp_q.push_back(3'b001);
    buf_in_commit = 1; tick(); buf_in_commit = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ep_commit !== 5'b00100) begin errors++; $display("FAIL commit_req cyc=%0d got=%b exp=00100", i, ep_commit); end
      if (i < 2) tick();
    end
    ep_commit_ack = 5'b00100; tick(); ep_commit_ack = '0;
    wait_evt(20, got);
    exp = pop_exp();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL commit_ack got=%b exp=%b", got, exp); end
    checks++;
    if (ep_commit !== '0) begin errors++; $display("FAIL commit_drop got=%b exp=0", ep_commit); end
    tick();
    checks++;
    if ({buf_in_commit_ack, busy} !== 2'b01) begin
      errors++; $display("FAIL commit_pulse_len ack,busy got=%b exp=01", {buf_in_commit_ack, busy});
    end
    end_txn();
  endtask

  task automatic test_timeout();
    logic [2:0] got, exp;
    int n;
    start_txn(4'd1);
    exp_q.push_back(3'b100);
    buf_out_arm = 1; tick(); buf_out_arm = 0;
    n = 0;
    for (int i = 0; i < 20 && !ack_timeout; i++) begin
      if (ep_arm === 5'b00010) n++;
      tick();
    end
    got = {ack_timeout, buf_out_arm_ack, buf_in_commit_ack};
    exp = pop_exp();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL timeout_evt got=%b exp=%b", got, exp); end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL timeout_len got=%0d exp=8", n); end
    checks++;
    if ({ep_arm, busy} !== '0) begin errors++; $display("FAIL timeout_idle got=%b exp=0", {ep_arm, busy}); end
    tick();
    checks++;
    if ({ack_timeout, buf_out_arm_ack} !== 2'b00) begin
      errors++; $display("FAIL timeout_once got=%b exp=00", {ack_timeout, buf_out_arm_ack});
    end
  endtask

  task automatic test_toggle();
    start_txn(4'd1);
    repeat (3) begin data_toggle_act = 1; tick(); data_toggle_act = 0; end
    checks++;
    if ({endp_mode, data_toggle} !== 4'b10_01) begin
      errors++; $display("FAIL toggle_bulk got=%b exp=1001", {endp_mode, data_toggle});
    end
    end_txn();
    start_txn(4'd3);
    repeat (3) begin data_toggle_act = 1; tick(); data_toggle_act = 0; end
    checks++;
    if ({endp_mode, data_toggle} !== 4'b01_00) begin
      errors++; $display("FAIL toggle_isoch got=%b exp=0100", {endp_mode, data_toggle});
    end
    end_txn();
    start_txn(4'd1);
    setconfig = 1; tick(); setconfig = 0;
    checks++;
    if (data_toggle !== 2'b00) begin errors++; $display("FAIL toggle_setconfig got=%b exp=00", data_toggle); end
    end_txn();
    start_txn(4'd0);
    setup_rx = 1; tick(); setup_rx = 0;
    checks++;
    if ({endp_mode, data_toggle} !== 4'b00_01) begin
      errors++; $display("FAIL toggle_setup got=%b exp=0001", {endp_mode, data_toggle});
    end
    halt_set = 1; tick(); halt_set = 0;
    checks++;
    if (endp_halted !== 1'b1) begin errors++; $display("FAIL ep0_halt got=%b exp=1", endp_halted); end
    setup_rx = 1; tick(); setup_rx = 0;
    checks++;
    if (endp_halted !== 1'b0) begin errors++; $display("FAIL ep0_halt_clr got=%b exp=0", endp_halted); end
    end_txn();
  endtask

  task automatic test_halt();
    logic [2:0] got, exp;
    start_txn(4'd4);
    data_toggle_act = 1; tick(); data_toggle_act = 0;
    halt_set = 1; tick(); halt_set = 0;
    buf_out_arm = 1; tick(); buf_out_arm = 0;
    checks++;
    if ({ep_arm, endp_halted, busy, data_toggle} !== {5'b0, 1'b1, 1'b1, 2'b01}) begin
      errors++; $display("FAIL halt_block got=%b exp=0000011 01", {ep_arm, endp_halted, busy, data_toggle});
    end
    wait_evt(5, got);
    checks++;
    if (got !== 3'b000) begin errors++; $display("FAIL halt_noack got=%b exp=000", got); end
    halt_clr = 1; tick(); halt_clr = 0;
    checks++;
    if ({endp_halted, data_toggle} !== 3'b000) begin
      errors++; $display("FAIL halt_clr got=%b exp=000", {endp_halted, data_toggle});
    end
    exp_q.push_back(3'b010);
    buf_out_arm = 1; tick(); buf_out_arm = 0;
    checks++;
    if (ep_arm !== 5'b10000) begin errors++; $display("FAIL halt_fwd got=%b exp=10000", ep_arm); end
    ep_arm_ack = 5'b10000; tick(); ep_arm_ack = '0;
    wait_evt(20, got);
    exp = pop_exp();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL halt_arm_ack got=%b exp=%b", got, exp); end
    end_txn();
  endtask

  task automatic test_invalid_priority();
    logic [2:0] got, exp;
    ep_buf_out_q = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ep_hasdata   = 5'b11111;
    start_txn(4'd7);
    checks++;
    if ({endp_invalid, buf_out_q, buf_out_hasdata, endp_mode, data_toggle, endp_halted} !== {1'b1, 14'b0}) begin
      errors++; $display("FAIL invalid_mux got=%b exp=1 followed by zeros", {endp_invalid, buf_out_q, buf_out_hasdata, endp_mode, data_toggle, endp_halted});
    end
    buf_in_commit = 1; tick(); buf_in_commit = 0;
    checks++;
    if ({ep_commit, busy} !== 6'b000001) begin errors++; $display("FAIL invalid_block got=%b exp=000001", {ep_commit, busy}); end
    wait_evt(4, got);
    checks++;
    if (got !== 3'b000) begin errors++; $display("FAIL invalid_noack got=%b exp=000", got); end
    end_txn();
    start_txn(4'd2);
    checks++;
    if ({buf_out_q, buf_out_hasdata, endp_mode, endp_invalid} !== {8'hA2, 1'b1, 2'b10, 1'b0}) begin
      errors++; $display("FAIL ep2_mux got=%h exp=%h", {buf_out_q, buf_out_hasdata, endp_mode, endp_invalid}, {8'hA2, 1'b1, 2'b10, 1'b0});
    end
    exp_q.push_back(3'b001);
    buf_in_commit = 1; buf_out_arm = 1; tick(); buf_in_commit = 0; buf_out_arm = 0;
    checks++;
    if ({ep_commit, ep_arm} !== {5'b00100, 5'b00000}) begin
      errors++; $display("FAIL prio_commit got=%b exp=0010000000", {ep_commit, ep_arm});
    end
    ep_commit_ack = 5'b00100; tick(); ep_commit_ack = '0;
    wait_evt(20, got);
    exp = pop_exp();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL prio_ack got=%b exp=%b", got, exp); end
    end_txn();
  endtask

  task automatic test_reset_mid_wait();
    start_txn(4'd1);
    data_toggle_act = 1; tick(); data_toggle_act = 0;
    end_txn();
    start_txn(4'd4);
    halt_set = 1; tick(); halt_set = 0;
    end_txn();
    start_txn(4'd2);
    buf_in_commit = 1; tick(); buf_in_commit = 0;
    checks++;
    if (ep_commit !== 5'b00100) begin errors++; $display("FAIL rst_pre got=%b exp=00100", ep_commit); end
    #2 reset_n = 0;
    #1;
    checks++;
    if ({ep_commit, busy} !== '0) begin errors++; $display("FAIL rst_async got=%b exp=0", {ep_commit, busy}); end
    tick();
    reset_n = 1;
    tick();
    checks++;
    if ({buf_in_commit_ack, buf_out_arm_ack, ack_timeout} !== 3'b000) begin
      errors++; $display("FAIL rst_noack got=%b exp=000", {buf_in_commit_ack, buf_out_arm_ack, ack_timeout});
    end
    start_txn(4'd1);
    checks++;
    if (data_toggle !== 2'b00) begin errors++; $display("FAIL rst_tog1 got=%b exp=00", data_toggle); end
    end_txn();
    start_txn(4'd4);
    checks++;
    if (endp_halted !== 1'b0) begin errors++; $display("FAIL rst_halt4 got=%b exp=0", endp_halted); end
    end_txn();
    start_txn(4'd0);
    checks++;
    if (data_toggle !== 2'b00) begin errors++; $display("FAIL rst_tog0 got=%b exp=00", data_toggle); end
    end_txn();
  endtask

  initial begin
    test_reset();
    test_commit();
    test_timeout();
    test_toggle();
    test_halt();
    test_invalid_priority();
    test_reset_mid_wait();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/usb2_ep_router.md
Name: usb2_ep_router

Overview:
- Parametrised endpoint router between the USB 2.0 packet layer and NUM_EP endpoint buffers.
- Generalises fixed per-endpoint muxing with registered endpoint selection and a commit/arm handshake state machine with ack timeout.
- Owns per-endpoint data-toggle state, per-endpoint mode, halt (STALL) state and invalid-endpoint detection.
- Sits in the protocol layer, clocked by phy_clk.

Parameters:
- NUM_EP, 5, number of endpoints including EP0; legal range 2..16.
- EP_MODES, 10'b10_01_10_10_00, 2 bits per endpoint, EP0 in the LSBs; 0=control, 1=isoch, 2=bulk, 3=interrupt. The EP0 field is ignored and EP0 is always control.
- ACK_TIMEOUT, 255, cycles to wait for an endpoint ack before aborting; must be ≥1.

Ports:
- phy_clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- sel_endp  in  4  endpoint number from the token
- txn_start  in  1  pulse; latch sel_endp
- txn_end  in  1  pulse; release the selection
- buf_in_commit  in  1  OUT-data commit request
- buf_out_arm  in  1  IN-data arm request
- data_toggle_act  in  1  pulse; advance the selected endpoint's toggle
- setup_rx  in  1  pulse; SETUP received on EP0
- setconfig  in  1  pulse; SET_CONFIGURATION
- halt_set  in  1  pulse; halt the selected endpoint
- halt_clr  in  1  pulse; clear halt on the selected endpoint
- ep_hasdata  in  NUM_EP  per-endpoint hasdata
- ep_buf_out_q  in  8*NUM_EP  per-endpoint read data, flattened
- ep_commit_ack  in  NUM_EP  per-endpoint commit ack
- ep_arm_ack  in  NUM_EP  per-endpoint arm ack
- ep_commit  out  NUM_EP  one-hot commit request
- ep_arm  out  NUM_EP  one-hot arm request
- buf_in_commit_ack  out  1  one-cycle pulse
- buf_out_arm_ack  out  1  one-cycle pulse
- buf_out_q  out  8  read data of the latched endpoint
- buf_out_hasdata  out  1  hasdata of the latched endpoint
- endp_mode  out  2  mode of the latched endpoint
- data_toggle  out  2  toggle of the latched endpoint
- endp_halted  out  1  latched endpoint is halted
- endp_invalid  out  1  latched endpoint is ≥ NUM_EP
- ack_timeout  out  1  one-cycle pulse on abort
- busy  out  1  state ≠ IDLE

Behaviour:
- Reset values:
  - All outputs 0.
  - Latched select 0, state IDLE.
  - All toggles 0, all halts 0.
- States:
  - IDLE: on txn_start, latch sel_endp and go to ACTIVE. txn_start outside IDLE is ignored.
  - ACTIVE: on buf_in_commit go to WAIT_C; otherwise on buf_out_arm go to WAIT_A. If both occur in the same cycle, commit wins and arm is dropped. On txn_end return to IDLE.
  - Halted or invalid endpoint: requests are not forwarded, state stays ACTIVE, and no ack is produced. The packet layer STALLs using endp_halted / endp_invalid.
  - WAIT_C / WAIT_A: ep_commit[sel] or ep_arm[sel] is held high from the cycle after the request. A timeout counter runs in parallel.
  - Ack sampled high at cycle M: at M+1 the request drops, buf_in_commit_ack or buf_out_arm_ack pulses, and the state returns to ACTIVE.
  - Counter reaches ACK_TIMEOUT with no ack: the request drops, ack_timeout pulses, no ack pulse is produced, and the state goes to IDLE.
  - txn_end during a WAIT state is ignored.
- Muxed outputs:
  - buf_out_q, buf_out_hasdata, endp_mode, data_toggle, endp_halted and endp_invalid are combinational from the latched select and registered state.
  - For an invalid endpoint these outputs are 0, except endp_invalid = 1.
- Toggle on data_toggle_act:
  - Control/bulk/interrupt: bit0 flips, bit1 stays 0.
  - Isoch: held at 0.
  - Invalid endpoint: no effect.
- setup_rx: EP0 toggle set to 2'b01.
- setconfig: clears the toggles and halts of EP1..NUM_EP-1. EP0 is untouched.
- halt_clr: clears the halt and the toggle of the latched endpoint.
- halt_set on EP0: clears automatically on the next setup_rx.
- Same-cycle priority on one endpoint: setconfig > halt_clr > setup_rx > data_toggle_act.
- Asynchronous reset mid-WAIT: all requests drop immediately; no ack pulse is issued.

Optional Feature:
- USB2_EP_ROUTER_STATS_EN defined adds three outputs:
  - txn_count [15:0]: increments on each ack pulse.
  - timeout_count [7:0]: increments on each ack_timeout.
  - stall_count [7:0]: increments on each request blocked by halt or invalid endpoint.
  - All counters saturate, reset to 0, and are cleared by setconfig.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Commit path: txn_start sel=2, buf_in_commit, ep_commit_ack[2] 3 cycles later.
  - ep_commit = 5'b00100 from the cycle after commit.
  - buf_in_commit_ack pulses 1 cycle; state ACTIVE.
- Toggle:
  - sel=1 (bulk), 3× data_toggle_act → data_toggle = 01.
  - sel=3 (isoch), 3× data_toggle_act → data_toggle = 00.
  - setconfig → EP1 toggle = 00.
- Halt:
  - halt_set on EP4 then buf_out_arm → ep_arm = 0, endp_halted = 1, no ack.
  - halt_clr → toggle 00; arm then forwards.
- Timeout: ACK_TIMEOUT=8, arm on EP1 with no ack → ack_timeout pulses once, ep_arm drops, busy = 0, buf_out_arm_ack never seen.
- Invalid/priority:
  - sel=7 → endp_invalid = 1, buf_out_q = 0.
  - Commit+arm in the same cycle on EP2 → only ep_commit asserted.
- Reset mid-WAIT: deassert reset_n during WAIT_C → ep_commit = 0 asynchronously; all toggles, halts and counters 0 after release.
